// File: rtl/tdm_demux.sv
// tdm_demux: rebuilds NCH parallel channels from a slot-aligned TDM sample stream
module tdm_demux #(
  parameter int NCH = 4,
  parameter int DW  = 1,
  parameter int SW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [NCH*DW-1:0] o,
  output logic              o_valid,
  output logic [SW-1:0]     s,
  output logic              err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                     state_q;
  logic [SW-1:0]              s_q;
  logic [NCH-2:0][DW-1:0]     shadow_q;
  logic [NCH*DW-1:0]          o_q;
  logic                       o_valid_q;
  logic                       err_q;
  // Framing FSM: hunt for sof, steer samples into shadow slots, publish full frames.
  // The last slot is never stored; it goes straight into o alongside the shadow.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      shadow_q  <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      err_q     <= 1'b0;
      if (din_valid) begin
        if (sof) begin
          shadow_q[0] <= din;
          s_q         <= SW'(1);
          state_q     <= RUN;
          err_q       <= (state_q == RUN) && (s_q != '0);
        end else if (state_q == RUN) begin
          if (s_q == '0) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (s_q == SW'(NCH-1)) begin
            o_q       <= {din, shadow_q};
            o_valid_q <= 1'b1;
            s_q       <= '0;
          end else begin
            shadow_q[s_q] <= din;
            s_q           <= s_q + SW'(1);
          end
        end
      end
    end
  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign s       = s_q;
  assign err     = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed and random frames against a queue-based framing model
module tb_tdm_demux;
  localparam int NCH = 4;
  localparam int DW  = 1;
  localparam int SW  = 2;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     din = '0;
  logic              din_valid = 1'b0;
  logic              sof = 1'b0;
  logic [NCH*DW-1:0] o;
  logic              o_valid;
  logic [SW-1:0]     s;
  logic              err;
  int n_chk = 0;
  int n_err = 0;
  bit                aligned = 1'b0;
  logic [DW-1:0]     cur[$];
  logic [NCH*DW-1:0] m_o = '0;
  bit                m_ov = 1'b0;
  bit                m_err = 1'b0;
  tdm_demux #(.NCH(NCH), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .o(o), .o_valid(o_valid), .s(s), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("o", 32'(o), 32'(m_o));
    chk("o_valid", 32'(o_valid), 32'(m_ov));
    chk("s", 32'(s), 32'(cur.size()));
    chk("err", 32'(err), 32'(m_err));
  endtask
  task automatic model(input logic v, input logic sf, input logic [DW-1:0] d);
    m_ov  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (sf) begin
        if (aligned && cur.size() != 0) m_err = 1'b1;
        cur.delete();
        cur.push_back(d);
        aligned = 1'b1;
      end else if (aligned) begin
        if (cur.size() == 0) begin
          m_err   = 1'b1;
          aligned = 1'b0;
        end else begin
          cur.push_back(d);
          if (cur.size() == NCH) begin
            for (int k = 0; k < NCH; k++) m_o[k*DW +: DW] = cur[k];
            m_ov = 1'b1;
            cur.delete();
          end
        end
      end
    end
  endtask
  task automatic step(input logic v, input logic sf, input logic [DW-1:0] d);
    din_valid = v;
    sof       = sf;
    din       = d;
    @(posedge clk);
    model(v, sf, d);
    #1 check_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    aligned = 1'b0;
    cur.delete();
    m_o   = '0;
    m_ov  = 1'b0;
    m_err = 1'b0;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    step(1, 1, 0); step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
    chk("t1_o", 32'(o), 32'h0000000a);
    chk("t1_ov", 32'(o_valid), 32'd1);
    step(0, 0, 0);
    chk("t1_ov_pulse", 32'(o_valid), 32'd0);
    step(1, 1, 0); step(1, 0, 1); step(0, 0, 1); step(0, 1, 0);
    chk("t2_s_gap", 32'(s), 32'd2);
    step(1, 0, 0); step(1, 0, 1);
    chk("t2_o", 32'(o), 32'h0000000a);
    step(1, 1, 1); step(1, 0, 1); step(1, 0, 0); step(1, 0, 0);
    chk("t3_o1", 32'(o), 32'h00000003);
    step(1, 1, 0); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
    chk("t3_o2", 32'(o), 32'h0000000c);
    step(1, 1, 0); step(1, 0, 1); step(1, 1, 1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_o_held", 32'(o), 32'h0000000c);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
    chk("t4_o", 32'(o), 32'h00000009);
    step(1, 0, 1);
    chk("t5_err", 32'(err), 32'd1);
    for (int i = 0; i < 5; i++) step(1, 0, 1);
    step(1, 1, 1); step(1, 0, 0);
    do_reset();
    chk("t6_o_rst", 32'(o), 32'd0);
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 0);
    chk("t6_o", 32'(o), 32'h00000005);
    for (int i = 0; i < 600; i++) begin
      logic v, sf;
      v  = ($urandom_range(3) != 0);
      sf = ($urandom_range(5) == 0) || (cur.size() == 0 && $urandom_range(1) == 1);
      step(v, sf, DW'($urandom));
      if (i == 300) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
